irq_trap_ctrl: RTL and testbench

Machine-mode interrupt and trap sequencer for the 3-stage RV32I pipeline.
- Samples the external, software and timer interrupt lines and applies mstatus.MIE/mie gating and fixed priority.
- Picks the cycle in which to take the interrupt, kills the instruction in Execute, and redirects fetch to mtvec.
- Drives the CSR-file update strobes (mepc, mcause, mstatus) and sequences mret returns.
- Sits beside the Controller; drives the pipeline flush and PC override.

---
 rtl/irq_trap_ctrl_if.sv | 37 +++
 rtl/irq_trap_ctrl.sv | 62 ++++++
 tb/tb_irq_trap_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/irq_trap_ctrl_if.sv
// irq_trap_ctrl_if: pipeline/CSR-side signals of the machine-mode interrupt and trap sequencer
interface irq_trap_ctrl_if #(parameter int XLEN = 32);
  logic ext_irq_i;
  logic sw_irq_i;
  logic tmr_irq_i;
  logic mstatus_mie_i;
  logic [2:0] mie_i;
  logic [XLEN-1:0] mtvec_i;
  logic [XLEN-1:0] mepc_i;
  logic [XLEN-1:0] pc_ex_i;
  logic ex_valid_i;
  logic ex_busy_i;
  logic is_mret_i;
  logic [2:0] mip_o;
  logic trap_take_o;
  logic mret_take_o;
  logic flush_o;
  logic pc_redirect_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic mepc_we_o;
  logic [XLEN-1:0] mepc_wdata_o;
  logic mcause_we_o;
  logic [XLEN-1:0] mcause_wdata_o;
  logic busy_o;
  modport master (
    output ext_irq_i, sw_irq_i, tmr_irq_i, mstatus_mie_i, mie_i, mtvec_i, mepc_i, pc_ex_i,
           ex_valid_i, ex_busy_i, is_mret_i,
    input  mip_o, trap_take_o, mret_take_o, flush_o, pc_redirect_o, redirect_pc_o,
           mepc_we_o, mepc_wdata_o, mcause_we_o, mcause_wdata_o, busy_o
  );
  modport slave (
    input  ext_irq_i, sw_irq_i, tmr_irq_i, mstatus_mie_i, mie_i, mtvec_i, mepc_i, pc_ex_i,
           ex_valid_i, ex_busy_i, is_mret_i,
    output mip_o, trap_take_o, mret_take_o, flush_o, pc_redirect_o, redirect_pc_o,
           mepc_we_o, mepc_wdata_o, mcause_we_o, mcause_wdata_o, busy_o
  );
endinterface

// File: rtl/irq_trap_ctrl.sv
// irq_trap_ctrl: machine-mode interrupt/mret sequencer; define TRAP_VECTORED_EN for vectored mtvec mode
module irq_trap_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int XLEN = 32
) (
  input logic clk,
  input logic reset,
  irq_trap_ctrl_if.slave bus
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  typedef enum logic {IDLE, SETTLE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] mip_q;
  logic [2:0] en;
  logic [3:0] code;
  logic [XLEN-1:0] cause;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] tvec;
  logic idle;
  logic mret_go;
  logic trap_go;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      mip_q <= '0;
    end else begin
      state <= state_n;
      mip_q <= {bus.ext_irq_i, bus.tmr_irq_i, bus.sw_irq_i};
      cnt <= (mret_go | trap_go) ? CW'(SETTLE_CYCLES - 1) : (cnt != '0) ? cnt - 1'b1 : cnt;
    end
  end
  always_comb begin
    idle = state == IDLE;
    en = mip_q & bus.mie_i;
    mret_go = idle & bus.is_mret_i & bus.ex_valid_i;
    trap_go = idle & (|en) & bus.mstatus_mie_i & bus.ex_valid_i & ~bus.ex_busy_i & ~bus.is_mret_i;
    state_n = idle ? ((mret_go | trap_go) ? SETTLE : IDLE) : ((cnt == '0) ? IDLE : SETTLE);
  end
  always_comb begin
    code = en[2] ? 4'd11 : en[0] ? 4'd3 : 4'd7;
    cause = {1'b1, {(XLEN-5){1'b0}}, code};
    base = {bus.mtvec_i[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    tvec = (bus.mtvec_i[1:0] == 2'b01) ? base + XLEN'({cause[4:0], 2'b00}) : base;
`else
    tvec = base;
`endif
    bus.mip_o = mip_q;
    bus.trap_take_o = trap_go & ~reset;
    bus.mret_take_o = mret_go & ~reset;
    bus.flush_o = (trap_go | mret_go) & ~reset;
    bus.pc_redirect_o = (trap_go | mret_go) & ~reset;
    bus.redirect_pc_o = mret_go ? bus.mepc_i : tvec;
    bus.mepc_we_o = trap_go & ~reset;
    bus.mepc_wdata_o = bus.pc_ex_i;
    bus.mcause_we_o = trap_go & ~reset;
    bus.mcause_wdata_o = cause;
    bus.busy_o = ~idle & ~reset;
  end
endmodule

// File: tb/tb_irq_trap_ctrl.sv
// tb_irq_trap_ctrl: directed scoreboard bench for irq_trap_ctrl (SETTLE_CYCLES=2)
module tb_irq_trap_ctrl;
  logic clk = 1'b0;
  logic reset;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic mret;
    logic [31:0] redir;
    logic [31:0] mepc;
    logic [31:0] cause;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [5:0] es;
  irq_trap_ctrl_if #(.XLEN(32)) bus ();
  irq_trap_ctrl #(.SETTLE_CYCLES(2), .XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(logic m, logic [31:0] r, logic [31:0] p, logic [31:0] c);
    exp_t x;
    x.mret = m;
    x.redir = r;
    x.mepc = p;
    x.cause = c;
    sb.push_back(x);
  endtask
  task automatic settle(string tag);
    tick();
    chk({tag, "_busy1"}, 32'(bus.busy_o), 32'd1);
    tick();
    chk({tag, "_busy2"}, 32'(bus.busy_o), 32'd1);
    tick();
    chk({tag, "_idle"}, 32'(bus.busy_o), 32'd0);
  endtask
  always @(negedge clk) begin
    es = 6'b0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      es = e.mret ? 6'b011100 : 6'b101111;
    end
    chk("strobes", 32'({bus.trap_take_o, bus.mret_take_o, bus.flush_o, bus.pc_redirect_o,
                        bus.mepc_we_o, bus.mcause_we_o}), 32'(es));
    if (es != 6'b0) begin
      chk("redirect_pc", bus.redirect_pc_o, e.redir);
      if (!e.mret) begin
        chk("mepc_wdata", bus.mepc_wdata_o, e.mepc);
        chk("mcause_wdata", bus.mcause_wdata_o, e.cause);
      end
    end
  end
  initial begin
    reset = 1'b1;
    bus.ext_irq_i = 1'b1;
    bus.sw_irq_i = 1'b0;
    bus.tmr_irq_i = 1'b0;
    bus.mstatus_mie_i = 1'b1;
    bus.mie_i = 3'b100;
    bus.mtvec_i = 32'h200;
    bus.mepc_i = 32'h0;
    bus.pc_ex_i = 32'h100;
    bus.ex_valid_i = 1'b1;
    bus.ex_busy_i = 1'b0;
    bus.is_mret_i = 1'b0;
    repeat (3) tick();
    chk("rst_mip", 32'(bus.mip_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    reset = 1'b0;
    bus.ext_irq_i = 1'b0;
    tick();
    bus.ext_irq_i = 1'b1;
    tick();
    chk("t1_mip", 32'(bus.mip_o), 32'd4);
    push(1'b0, 32'h200, 32'h100, 32'h8000000B);
    bus.ext_irq_i = 1'b0;
    settle("t1");
    bus.mie_i = 3'b111;
    {bus.ext_irq_i, bus.sw_irq_i, bus.tmr_irq_i} = 3'b111;
    tick();
    push(1'b0, 32'h200, 32'h100, 32'h8000000B);
    bus.ext_irq_i = 1'b0;
    settle("t2a");
    push(1'b0, 32'h200, 32'h100, 32'h80000003);
    bus.sw_irq_i = 1'b0;
    settle("t2b");
    push(1'b0, 32'h200, 32'h100, 32'h80000007);
    bus.tmr_irq_i = 1'b0;
    settle("t2c");
    bus.mepc_i = 32'h344;
    bus.pc_ex_i = 32'h140;
    bus.ext_irq_i = 1'b1;
    tick();
    bus.is_mret_i = 1'b1;
    push(1'b1, 32'h344, 32'h0, 32'h0);
    tick();
    bus.is_mret_i = 1'b0;
    chk("t3_busy1", 32'(bus.busy_o), 32'd1);
    tick();
    chk("t3_busy2", 32'(bus.busy_o), 32'd1);
    tick();
    push(1'b0, 32'h200, 32'h140, 32'h8000000B);
    bus.ext_irq_i = 1'b0;
    settle("t3");
    bus.pc_ex_i = 32'h240;
    bus.mstatus_mie_i = 1'b0;
    bus.ext_irq_i = 1'b1;
    tick();
    chk("t4a_mip1", 32'(bus.mip_o), 32'd4);
    tick();
    chk("t4a_mip2", 32'(bus.mip_o), 32'd4);
    bus.mstatus_mie_i = 1'b1;
    push(1'b0, 32'h200, 32'h240, 32'h8000000B);
    bus.ext_irq_i = 1'b0;
    settle("t4a");
    bus.ex_busy_i = 1'b1;
    bus.tmr_irq_i = 1'b1;
    tick();
    chk("t4b_mip", 32'(bus.mip_o), 32'd2);
    tick();
    bus.ex_busy_i = 1'b0;
    push(1'b0, 32'h200, 32'h240, 32'h80000007);
    bus.tmr_irq_i = 1'b0;
    settle("t4b");
    bus.ex_valid_i = 1'b0;
    bus.sw_irq_i = 1'b1;
    tick();
    chk("t4c_mip", 32'(bus.mip_o), 32'd1);
    tick();
    bus.ex_valid_i = 1'b1;
    push(1'b0, 32'h200, 32'h240, 32'h80000003);
    bus.sw_irq_i = 1'b0;
    settle("t4c");
    bus.ext_irq_i = 1'b1;
    tick();
    push(1'b0, 32'h200, 32'h240, 32'h8000000B);
    tick();
    chk("t5_settle", 32'(bus.busy_o), 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_rst_busy1", 32'(bus.busy_o), 32'd0);
    tick();
    chk("t5_rst_busy2", 32'(bus.busy_o), 32'd0);
    tick();
    reset = 1'b0;
    chk("t5_rel_mip", 32'(bus.mip_o), 32'd0);
    chk("t5_rel_busy", 32'(bus.busy_o), 32'd0);
    tick();
    push(1'b0, 32'h200, 32'h240, 32'h8000000B);
    bus.ext_irq_i = 1'b0;
    settle("t5");
    bus.mtvec_i = 32'h201;
    bus.tmr_irq_i = 1'b1;
    tick();
`ifdef TRAP_VECTORED_EN
    push(1'b0, 32'h21C, 32'h240, 32'h80000007);
`else
    push(1'b0, 32'h200, 32'h240, 32'h80000007);
`endif
    bus.tmr_irq_i = 1'b0;
    settle("t6");
    bus.is_mret_i = 1'b1;
    push(1'b1, 32'h344, 32'h0, 32'h0);
    tick();
    bus.is_mret_i = 1'b0;
    chk("t6_mret_busy", 32'(bus.busy_o), 32'd1);
    tick();
    tick();
    chk("t6_final_idle", 32'(bus.busy_o), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
